// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS control FSM with ready-based memory handshake
// Moore-decoded datapath strobes; only FETCH/MEMWR completion and BRANCH PC load look at inputs.
module mc_control_fsm #(
  parameter int MAX_WAIT   = 16,
  parameter bit ENABLE_JAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] operation,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       instr_or_data,
  output logic       instr_reg_we,
  output logic       pc_reg_we,
  output logic       reg_we,
  output logic [1:0] reg_write_addr,
  output logic [1:0] reg_write_data,
  output logic [1:0] alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_controller,
  output logic       retire,
  output logic       fault
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_IMMEX  = 4'd8;
  localparam logic [3:0] S_IMMWB  = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_FAULT  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

  logic [3:0]    state;
  logic [3:0]    next_state;
  logic [CW-1:0] wait_cnt;
  logic          active;
  logic          wait_state;
  logic          timeout;
  logic [2:0]    r_alu;
  logic          r_legal;
  logic [2:0]    i_alu;

  assign wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout    = (MAX_WAIT > 0) && wait_state && !mem_ready && (wait_cnt == WAIT_LIM);

  always_comb begin
    r_legal = 1'b1;
    case (func)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default: begin
        r_alu   = ALU_ADD;
        r_legal = 1'b0;
      end
    endcase
    case (operation)
      OP_ANDI: i_alu = ALU_AND;
      OP_ORI:  i_alu = ALU_OR;
      OP_SLTI: i_alu = ALU_SLT;
      default: i_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    next_state     = state;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    instr_or_data  = 1'b0;
    instr_reg_we   = 1'b0;
    pc_reg_we      = 1'b0;
    reg_we         = 1'b0;
    reg_write_addr = 2'd0;
    reg_write_data = 2'd0;
    alu_src_a      = 2'd0;
    alu_src_b      = 3'd0;
    pc_src         = 2'd0;
    alu_controller = ALU_ADD;
    retire         = 1'b0;
    fault          = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 3'd1;
        if (mem_ready) begin
          instr_reg_we = 1'b1;
          pc_reg_we    = 1'b1;
          next_state   = S_DECODE;
        end else if (timeout) begin
          next_state = S_FAULT;
        end
      end
      S_DECODE: begin
        alu_src_b = 3'd3;
        case (operation)
          OP_RTYPE:                         next_state = S_EXEC;
          OP_LW, OP_SW:                     next_state = S_MEMADR;
          OP_BEQ, OP_BNE:                   next_state = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_IMMEX;
          OP_J:                             next_state = S_JUMP;
          OP_JAL:                           next_state = ENABLE_JAL ? S_JUMP : S_FAULT;
          default:                          next_state = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 3'd2;
        next_state = (operation == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req       = 1'b1;
        instr_or_data = 1'b1;
        if (mem_ready)    next_state = S_MEMWB;
        else if (timeout) next_state = S_FAULT;
      end
      S_MEMWB: begin
        reg_we         = 1'b1;
        reg_write_data = 2'd1;
        retire         = 1'b1;
        next_state     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req       = 1'b1;
        mem_we        = 1'b1;
        instr_or_data = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end else if (timeout) begin
          next_state = S_FAULT;
        end
      end
      S_EXEC: begin
        alu_src_a      = 2'd1;
        alu_controller = r_alu;
        next_state     = r_legal ? S_ALUWB : S_FAULT;
      end
      S_ALUWB: begin
        reg_we         = 1'b1;
        reg_write_addr = 2'd1;
        retire         = 1'b1;
        next_state     = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a      = 2'd1;
        alu_src_b      = (operation == OP_ANDI || operation == OP_ORI) ? 3'd4 : 3'd2;
        alu_controller = i_alu;
        next_state     = S_IMMWB;
      end
      S_IMMWB: begin
        reg_we     = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a      = 2'd1;
        alu_controller = ALU_SUB;
        pc_src         = 2'd1;
        pc_reg_we      = (operation == OP_BEQ) ? zero : !zero;
        retire         = 1'b1;
        next_state     = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'd2;
        pc_reg_we  = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
        if (operation == OP_JAL) begin
          reg_we         = 1'b1;
          reg_write_addr = 2'd2;
          reg_write_data = 2'd2;
        end
      end
      S_FAULT: fault = 1'b1;
      default: next_state = S_FAULT;
    endcase
    // Nothing may request or write until the first edge that samples reset released.
    if (!(rst && active)) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      instr_reg_we = 1'b0;
      pc_reg_we    = 1'b0;
      reg_we       = 1'b0;
      retire       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      active   <= 1'b0;
    end else if (!active) begin
      active <= 1'b1;
    end else begin
      state <= next_state;
      if (next_state != state || mem_ready) wait_cnt <= '0;
      else if (wait_state)                  wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm
// Stimulus queues expected retire/fault records; a negedge monitor pops and compares.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] operation = 6'd0;
  logic [5:0] func = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, instr_or_data, instr_reg_we, pc_reg_we, reg_we;
  logic [1:0] reg_write_addr, reg_write_data, alu_src_a, pc_src;
  logic [2:0] alu_src_b, alu_controller;
  logic       retire, fault;

  logic       nj_mem_req, nj_mem_we, nj_iod, nj_irw, nj_pcwe, nj_rwe, nj_retire, nj_fault;
  logic [1:0] nj_wa, nj_wd, nj_asa, nj_psrc;
  logic [2:0] nj_asb, nj_alu;

  mc_control_fsm #(.MAX_WAIT(4), .ENABLE_JAL(1'b1)) dut (
    .clk(clk), .rst(rst), .operation(operation), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .instr_or_data(instr_or_data), .instr_reg_we(instr_reg_we), .pc_reg_we(pc_reg_we),
    .reg_we(reg_we), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_controller(alu_controller), .retire(retire), .fault(fault)
  );

  mc_control_fsm #(.MAX_WAIT(4), .ENABLE_JAL(1'b0)) dut_nj (
    .clk(clk), .rst(rst), .operation(operation), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(nj_mem_req), .mem_we(nj_mem_we),
    .instr_or_data(nj_iod), .instr_reg_we(nj_irw), .pc_reg_we(nj_pcwe),
    .reg_we(nj_rwe), .reg_write_addr(nj_wa), .reg_write_data(nj_wd),
    .alu_src_a(nj_asa), .alu_src_b(nj_asb), .pc_src(nj_psrc),
    .alu_controller(nj_alu), .retire(nj_retire), .fault(nj_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_fault;
    int       cyc;
    bit       rwe;
    bit [1:0] wa;
    bit [1:0] wd;
    bit       pwe;
    bit       chk_psrc;
    bit [1:0] psrc;
    bit       mwe;
    int       alu_mode;
    bit [2:0] alu;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   fetch_wait = 0;
  int   mem_wait = 0;
  bit   tb_run = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int cyc, input bit rwe, input int wa, input int wd,
                              input bit pwe, input bit cp, input int ps, input bit mwe,
                              input int am, input int alu);
    exp_t e;
    e.is_fault = 1'b0; e.cyc = cyc; e.rwe = rwe; e.wa = 2'(wa); e.wd = 2'(wd);
    e.pwe = pwe; e.chk_psrc = cp; e.psrc = 2'(ps); e.mwe = mwe;
    e.alu_mode = am; e.alu = 3'(alu);
    return e;
  endfunction

  function automatic exp_t mk_fault(input int cyc);
    exp_t e;
    e = mk(cyc, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    e.is_fault = 1'b1;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    tb_run = rst;
  end

  // Memory model: ready after the requested number of wait cycles for each access.
  initial begin
    int  age;
    bit  prev_req, prev_rdy;
    age = 0; prev_req = 0; prev_rdy = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!mem_req)                  age = 0;
      else if (prev_req && !prev_rdy) age++;
      else                           age = 0;
      mem_ready = mem_req && (age == (instr_or_data ? mem_wait : fetch_wait));
      prev_req  = mem_req;
      prev_rdy  = mem_ready;
    end
  end

  initial begin
    int cyc, irw_cnt;
    bit rwe_seen, fault_seen, hs_prev, p_we, p_iod;
    logic [2:0] prev_alu;
    exp_t e;
    cyc = 0; irw_cnt = 0; rwe_seen = 0; fault_seen = 0; hs_prev = 0;
    p_we = 0; p_iod = 0; prev_alu = 3'd0;
    forever begin
      @(negedge clk);
      if (!tb_run) begin
        cyc = 0; irw_cnt = 0; rwe_seen = 0; fault_seen = 0; hs_prev = 0;
      end else begin
        cyc++;
        if (instr_reg_we) irw_cnt++;
        if (reg_we) rwe_seen = 1;
        if (hs_prev && rst && !fault) begin
          chk("hs_mem_req_held", mem_req, 1);
          chk("hs_mem_we_held", mem_we, p_we);
          chk("hs_instr_or_data_held", instr_or_data, p_iod);
        end
        hs_prev = rst && mem_req && !mem_ready;
        p_we = mem_we; p_iod = instr_or_data;
        if (retire || (fault && !fault_seen)) begin
          if (fault) fault_seen = 1;
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: event at cycle %0d, expected none", cyc);
          end else begin
            e = sb.pop_front();
            if (e.is_fault != fault) begin
              n_fail++;
              $display("FAIL sb_kind: got fault=%0d, expected fault=%0d", fault, e.is_fault);
            end
            chk("latency", cyc, e.cyc);
            chk("instr_reg_we_count", irw_cnt, 1);
            if (e.is_fault) begin
              chk("fault_no_reg_we", rwe_seen, 0);
            end else begin
              chk("reg_we", reg_we, e.rwe);
              if (e.rwe) begin
                chk("reg_write_addr", reg_write_addr, e.wa);
                chk("reg_write_data", reg_write_data, e.wd);
              end
              chk("pc_reg_we", pc_reg_we, e.pwe);
              if (e.chk_psrc) chk("pc_src", pc_src, e.psrc);
              chk("mem_we", mem_we, e.mwe);
              if (e.alu_mode == 1) chk("alu_exec", prev_alu, e.alu);
              if (e.alu_mode == 2) chk("alu_branch", alu_controller, e.alu);
            end
          end
          cyc = 0; irw_cnt = 0; rwe_seen = 0;
        end
        prev_alu = alu_controller;
      end
    end
  end

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int fw, input int mw, input exp_t e);
    bit done;
    operation = op; func = fn; zero = z; fetch_wait = fw; mem_wait = mw;
    sb.push_back(e);
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (retire || fault) done = 1;
    end
    if (!done) chk("timeout_no_retire", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retire", retire, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_instr_reg_we", instr_reg_we, 0);
    chk("rst_pc_reg_we", pc_reg_we, 0);
    do_reset();

    run(6'b000000, 6'b100000, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, 0, 1, 3'b010));
    run(6'b000000, 6'b100010, 0, 1, 0, mk(5, 1, 1, 0, 0, 0, 0, 0, 1, 3'b110));
    run(6'b000000, 6'b101010, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, 0, 1, 3'b111));
    run(6'b000000, 6'b100100, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, 0, 1, 3'b000));
    run(6'b000000, 6'b100101, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, 0, 1, 3'b001));
    run(6'b100011, 6'b000000, 0, 3, 2, mk(10, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    run(6'b101011, 6'b000000, 0, 0, 1, mk(5, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    run(6'b101011, 6'b000000, 0, 0, 4, mk(8, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    run(6'b000100, 6'b000000, 0, 0, 0, mk(3, 0, 0, 0, 0, 1, 1, 0, 2, 3'b110));
    run(6'b000101, 6'b000000, 0, 0, 0, mk(3, 0, 0, 0, 1, 1, 1, 0, 2, 3'b110));
    run(6'b000100, 6'b000000, 1, 0, 0, mk(3, 0, 0, 0, 1, 1, 1, 0, 2, 3'b110));
    run(6'b000101, 6'b000000, 1, 0, 0, mk(3, 0, 0, 0, 0, 1, 1, 0, 2, 3'b110));
    run(6'b001000, 6'b000000, 0, 0, 0, mk(4, 1, 0, 0, 0, 0, 0, 0, 1, 3'b010));
    run(6'b001100, 6'b000000, 0, 0, 0, mk(4, 1, 0, 0, 0, 0, 0, 0, 1, 3'b000));
    run(6'b001101, 6'b000000, 0, 0, 0, mk(4, 1, 0, 0, 0, 0, 0, 0, 1, 3'b001));
    run(6'b001010, 6'b000000, 0, 0, 0, mk(4, 1, 0, 0, 0, 0, 0, 0, 1, 3'b111));
    run(6'b000010, 6'b000000, 0, 0, 0, mk(3, 0, 0, 0, 1, 1, 2, 0, 0, 0));
    chk("nojal_fault_before_jal", nj_fault, 0);
    run(6'b000011, 6'b000000, 0, 0, 0, mk(3, 1, 2, 2, 1, 1, 2, 0, 0, 0));
    chk("nojal_fault_after_jal", nj_fault, 1);
    chk("nojal_no_mem_req", nj_mem_req, 0);

    run(6'b000000, 6'b001000, 0, 0, 0, mk_fault(4));
    do_reset();
    run(6'b111111, 6'b000000, 0, 0, 0, mk_fault(3));
    do_reset();

    run(6'b101011, 6'b000000, 0, 0, 99, mk_fault(9));
    repeat (3) @(negedge clk);
    chk("fault_sticky", fault, 1);
    chk("fault_mem_req", mem_req, 0);
    chk("fault_mem_we", mem_we, 0);
    chk("fault_reg_we", reg_we, 0);
    fetch_wait = 3;
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("resume_fault_clear", fault, 0);
    chk("resume_mem_req", mem_req, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("midreset_mem_req", mem_req, 0);
    chk("midreset_instr_reg_we", instr_reg_we, 0);
    chk("midreset_pc_reg_we", pc_reg_we, 0);
    fetch_wait = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run(6'b000000, 6'b100000, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, 0, 1, 3'b010));

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control unit for the MIPS core with a ready-based memory handshake, a bus-timeout fault, and an extended instruction set. It holds the instruction-sequencing FSM that drives the existing datapath strobes. It slows fetch, load and store to any number of memory wait states, so the core can sit behind slow or shared memory.

## Interface
- MAX_WAIT, 16: maximum wait cycles per memory access before fault; 0 disables the timeout.
- ENABLE_JAL, 1: 1 decodes jal; 0 treats jal as illegal.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- operation  in  6  instruction bits [31:26] from the instruction register.
- func  in  6  instruction bits [5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request; held until mem_ready.
- mem_we  out  1  write qualifier; valid only with mem_req.
- instr_or_data  out  1  address select: 0=PC, 1=ALUOut.
- instr_reg_we  out  1  instruction register load.
- pc_reg_we  out  1  PC load.
- reg_we  out  1  register file write.
- reg_write_addr  out  2  0=rt, 1=rd, 2=$31.
- reg_write_data  out  2  0=ALUOut, 1=MDR, 2=PC.
- alu_src_a  out  2  0=PC, 1=reg A.
- alu_src_b  out  3  0=reg B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2, 4=zero-ext imm.
- pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target.
- alu_controller  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- retire  out  1  one-cycle pulse in the final cycle of each instruction.
- fault  out  1  sticky; illegal instruction or memory timeout.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IMMEX, IMMWB, BRANCH, JUMP, FAULT.
- Outputs are Moore-decoded from state. The exceptions are the handshake-qualified strobes and the BRANCH PC load.
- All strobes are 0 unless listed below.
- **FETCH**
  - mem_req=1, instr_or_data=0, alu_src_a=0, alu_src_b=1, add, pc_src=0.
  - On mem_ready: instr_reg_we=1, pc_reg_we=1, go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE**
  - alu_src_a=0, alu_src_b=3, add (branch target into ALUOut).
  - Dispatch by opcode:
    - 000000 → EXEC.
    - 100011 or 101011 → MEMADR.
    - 000100 or 000101 → BRANCH.
    - 001000, 001100, 001101 or 001010 → IMMEX.
    - 000010, or 000011 when ENABLE_JAL=1 → JUMP.
    - Any other opcode → FAULT.
- **MEMADR**: alu_src_a=1, alu_src_b=2, add. Go to MEMRD for lw, MEMWR for sw.
- **MEMRD**: mem_req=1, instr_or_data=1. On mem_ready go to MEMWB.
- **MEMWB**: reg_we=1, reg_write_addr=0, reg_write_data=1, retire=1, go to FETCH.
- **MEMWR**: mem_req=1, mem_we=1, instr_or_data=1. On mem_ready: retire=1, go to FETCH.
- **EXEC**
  - alu_src_a=1, alu_src_b=0.
  - func 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other func → FAULT; no register write occurs.
- **ALUWB**: reg_we=1, reg_write_addr=1, reg_write_data=0, retire=1, go to FETCH.
- **IMMEX**
  - alu_src_a=1.
  - addi: alu_src_b=2, add. slti: alu_src_b=2, slt.
  - andi: alu_src_b=4, and. ori: alu_src_b=4, or.
- **IMMWB**: reg_we=1, reg_write_addr=0, reg_write_data=0, retire=1, go to FETCH.
- **BRANCH**
  - alu_src_a=1, alu_src_b=0, sub, pc_src=1, retire=1, go to FETCH.
  - pc_reg_we = zero for beq, !zero for bne.
- **JUMP**
  - pc_src=2, pc_reg_we=1, retire=1, go to FETCH.
  - jal also drives reg_we=1, reg_write_addr=2, reg_write_data=2; the PC already holds PC+4.
- **FAULT**
  - fault=1; all strobes and mem_req are 0.
  - Absorbing state; only reset leaves it.
- **Wait counter**
  - Cleared on every entry to FETCH, MEMRD or MEMWR, and on mem_ready.
  - Increments each cycle in those states while mem_ready=0.
  - If MAX_WAIT>0 and the counter reaches MAX_WAIT with mem_ready still 0, the next state is FAULT.
  - mem_ready arriving in the same cycle as the limit wins: the access completes normally.
  - Counter width is $clog2(MAX_WAIT+1), with a minimum of 1.

## Timing
- While rst=0 at a clock edge: state←FETCH, counter←0, fault←0.
- During reset cycles, mem_req, all write enables and retire are forced to 0.
- The first mem_req is asserted in the cycle after rst is sampled 1.
- Latency with zero wait states (mem_ready=1 on first request):
  - beq, bne, j, jal: 3 cycles.
  - R-type, immediate ops, sw: 4 cycles.
  - lw: 5 cycles.
- Each wait cycle adds exactly one cycle to FETCH, MEMRD or MEMWR.
- Handshake: mem_req, mem_we, instr_or_data and the ALU selects stay stable until mem_ready is sampled 1.
- instr_reg_we and pc_reg_we in FETCH are high only in the mem_ready cycle.
- Reset asserted mid-access drops mem_req the same cycle. No partial write strobe is issued after reset.

## Test plan
- Zero-wait R-type add (op 000000, func 100000): states FETCH, DECODE, EXEC, ALUWB; reg_we=1 with reg_write_addr=1 in cycle 4; retire pulses once.
- lw with mem_ready low 3 cycles in FETCH and 2 cycles in MEMRD: retire in cycle 10; instr_reg_we asserted exactly once; mem_req continuous in each wait.
- beq with zero=0 then bne with zero=0: pc_reg_we=0 in BRANCH for beq, 1 for bne; each takes 3 cycles.
- jal with ENABLE_JAL=1: JUMP drives reg_write_addr=2, reg_write_data=2, pc_src=2. With ENABLE_JAL=0, the same opcode reaches FAULT after DECODE.
- MAX_WAIT=4, mem_ready held 0 in MEMWR: FAULT entered after 4 wait cycles; mem_we drops; fault stays 1 until rst=0, then FETCH resumes.
- Illegal func 001000 in EXEC: fault=1 next cycle, reg_we never asserted. rst=0 during a FETCH wait: mem_req=0 in that cycle.
